// File: rtl/rv32i_memoryaccess_if.sv
// Pipelined Wishbone data-bus bundle between the memory-access stage (master)
// and the data memory / peripheral fabric (slave).
interface rv32i_memoryaccess_if;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [31:0] wb_addr;
   logic [31:0] wb_wdata;
   logic [3:0]  wb_sel;
   logic        wb_ack;
   logic        wb_stall;
   logic [31:0] wb_rdata;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
      input  wb_ack, wb_stall, wb_rdata
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
      output wb_ack, wb_stall, wb_rdata
   );
endinterface

// File: rtl/rv32i_memoryaccess.sv
// RV32I memory-access stage: turns the execute-stage address/store data into a
// single pipelined Wishbone transaction, stalls upstream until it completes,
// then aligns and extends load data and hands everything on to writeback.
module rv32i_memoryaccess #(
   parameter int ACK_TIMEOUT  = 255,
   parameter int OPCODE_WIDTH = 11,
   parameter int LOAD_BIT     = 0,
   parameter int STORE_BIT    = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   rv32i_memoryaccess_if.master    wb,
   input  logic [31:0]             i_y,
   input  logic [31:0]             i_rs2,
   input  logic [2:0]              i_funct3,
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic [31:0]             i_pc,
   input  logic [4:0]              i_rd_addr,
   input  logic [31:0]             i_rd,
   input  logic                    i_rd_valid,
   input  logic                    i_wr_rd,
   input  logic                    i_ce,
   input  logic                    i_stall,
   input  logic                    i_flush,
   output logic [31:0]             o_data_load,
   output logic [31:0]             o_pc,
   output logic [4:0]              o_rd_addr,
   output logic [31:0]             o_rd,
   output logic                    o_rd_valid,
   output logic                    o_wr_rd,
   output logic [2:0]              o_funct3,
   output logic [OPCODE_WIDTH-1:0] o_opcode,
   output logic                    o_misaligned,
   output logic                    o_bus_err,
   output logic                    o_ce,
   output logic                    o_stall,
   output logic                    o_flush
);

   // Counter only needs to reach ACK_TIMEOUT-1: the abort fires during the last WAIT cycle.
   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam bit TMO_EN = (ACK_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             cyc_q, cyc_d;
   logic             stb_q, stb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             capture;
   logic             timeout;

   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       sel_q;
   logic [31:0]      rdata_p1;
   logic             err_q;
   logic             flush_q;

   logic             mem_op;
   logic             misal;
   logic             issue;
   logic             bus_busy;
   logic             stall_bit;
   logic             stage_upd;
   logic             leave_done;

   // Byte-lane enables for the access size at byte offset off.
   function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] s;
      case (f3[1:0])
         2'b00:   s = 4'b0001 << off;
         2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   // Store data replicated on every lane so the slave picks it up via sel.
   function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] rs2);
      logic [31:0] d;
      case (f3[1:0])
         2'b00:   d = {4{rs2[7:0]}};
         2'b01:   d = {2{rs2[15:0]}};
         default: d = rs2;
      endcase
      return d;
   endfunction

   // Pick the addressed byte/half out of the read word and extend it.
   function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] sx;
      logic [31:0]        r;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      sx = '0;
      case (f3)
         3'b000:  begin sx = b; r = sx; end
         3'b001:  begin sx = h; r = sx; end
         3'b100:  r = {24'b0, b};
         3'b101:  r = {16'b0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   assign mem_op   = i_opcode[LOAD_BIT] | i_opcode[STORE_BIT];
   assign misal    = (((i_funct3 == 3'd1) || (i_funct3 == 3'd5)) && i_y[0]) ||
                     ((i_funct3 == 3'd2) && (i_y[1:0] != 2'b00));
   assign issue    = (state_q == S_IDLE) && i_ce && mem_op && !misal && !i_flush && !i_stall;
   assign bus_busy = (state_q == S_REQ) || (state_q == S_WAIT);

   // A flush cannot cancel an in-flight bus cycle, so REQ/WAIT keep stalling regardless.
   assign o_stall    = i_rst_n & ((((i_stall | issue) & !i_flush)) | bus_busy);
   assign stall_bit  = o_stall | i_stall;
   assign stage_upd  = i_ce & !stall_bit;
   assign leave_done = (state_q == S_DONE) && !i_stall;
   assign o_flush    = i_flush;

   assign wb.wb_cyc   = cyc_q;
   assign wb.wb_stb   = stb_q;
   assign wb.wb_we    = we_q;
   assign wb.wb_addr  = addr_q;
   assign wb.wb_wdata = wdata_q;
   assign wb.wb_sel   = sel_q;

   // FSM state, bus strobes and ack-timeout counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: one transaction at a time, cyc held from stb until ack or abort.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      timeout = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (issue) begin
               state_d = S_REQ;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
            end
         end
         S_REQ: begin
            if (!wb.wb_stall) begin
               stb_d = 1'b0;
               if (wb.wb_ack) begin
                  cyc_d   = 1'b0;
                  capture = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (wb.wb_ack) begin
               cyc_d   = 1'b0;
               capture = 1'b1;
               state_d = S_DONE;
            end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
               cyc_d   = 1'b0;
               timeout = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            cnt_d = '0;
            if (!i_stall) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Address, lane select, write flag and store data latched at issue, stable while stb is stalled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
      end else if (issue) begin
         we_q    <= i_opcode[STORE_BIT];
         addr_q  <= {i_y[31:2], 2'b00};
         wdata_q <= lane_data(i_funct3, i_rs2);
         sel_q   <= lane_sel(i_funct3, i_y[1:0]);
      end
   end

   // Read word capture and per-transaction error/flush memory, cleared as DONE hands off.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdata_p1 <= '0;
         err_q    <= 1'b0;
         flush_q  <= 1'b0;
      end else begin
         if (capture) rdata_p1 <= wb.wb_rdata;
         if (timeout) err_q <= 1'b1;
         else if (leave_done) err_q <= 1'b0;
         if (bus_busy && i_flush) flush_q <= 1'b1;
         else if (leave_done) flush_q <= 1'b0;
      end
   end

   // ---- writeback stage boundary ----
   // Stage registers toward writeback: pass-through fields, aligned load data, status flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data_load  <= '0;
         o_pc         <= '0;
         o_rd_addr    <= '0;
         o_rd         <= '0;
         o_rd_valid   <= 1'b0;
         o_wr_rd      <= 1'b0;
         o_funct3     <= '0;
         o_opcode     <= '0;
         o_misaligned <= 1'b0;
         o_bus_err    <= 1'b0;
      end else begin
         if (stage_upd) begin
            o_data_load  <= load_align(i_funct3, i_y[1:0], rdata_p1);
            o_pc         <= i_pc;
            o_rd_addr    <= i_rd_addr;
            o_rd         <= i_rd;
            o_rd_valid   <= i_rd_valid;
            // Stores, faulted and aborted accesses never write the register file.
            o_wr_rd      <= i_wr_rd & !(mem_op & misal) & !i_opcode[STORE_BIT] & !err_q;
            o_funct3     <= i_funct3;
            o_opcode     <= i_opcode;
            o_misaligned <= mem_op & misal;
         end
         if (timeout) o_bus_err <= 1'b1;
         else if (stage_upd) o_bus_err <= err_q;
      end
   end

   // Writeback enable: bubble while we stall on our own, hold while downstream stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ce <= 1'b0;
      end else if (!stall_bit) begin
         o_ce <= i_ce & !(i_flush | flush_q);
      end else if (!i_stall) begin
         o_ce <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32i_memoryaccess.sv
// Bench for rv32i_memoryaccess: directed vector table, flush and reset
// sequences, then random traffic against a byte-level reference model.
module tb_rv32i_memoryaccess;
   localparam int TMO = 8;
   localparam int OPW = 11;
   localparam int LDB = 0;
   localparam int STB = 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [31:0]    i_y, i_rs2, i_pc, i_rd;
   logic [2:0]     i_funct3;
   logic [OPW-1:0] i_opcode;
   logic [4:0]     i_rd_addr;
   logic           i_rd_valid, i_wr_rd, i_ce, i_stall, i_flush;
   logic [31:0]    o_data_load, o_pc, o_rd;
   logic [4:0]     o_rd_addr;
   logic           o_rd_valid, o_wr_rd, o_misaligned, o_bus_err, o_ce, o_stall, o_flush;
   logic [2:0]     o_funct3;
   logic [OPW-1:0] o_opcode;

   rv32i_memoryaccess_if bus ();

   rv32i_memoryaccess #(.ACK_TIMEOUT(TMO), .OPCODE_WIDTH(OPW), .LOAD_BIT(LDB), .STORE_BIT(STB)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .wb(bus.master),
      .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3), .i_opcode(i_opcode),
      .i_pc(i_pc), .i_rd_addr(i_rd_addr), .i_rd(i_rd), .i_rd_valid(i_rd_valid), .i_wr_rd(i_wr_rd),
      .i_ce(i_ce), .i_stall(i_stall), .i_flush(i_flush),
      .o_data_load(o_data_load), .o_pc(o_pc), .o_rd_addr(o_rd_addr), .o_rd(o_rd),
      .o_rd_valid(o_rd_valid), .o_wr_rd(o_wr_rd), .o_funct3(o_funct3), .o_opcode(o_opcode),
      .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .o_ce(o_ce), .o_stall(o_stall),
      .o_flush(o_flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;     // 0 load, 1 store, 2 non-memory
      logic [2:0]  f3;
      logic [31:0] y;
      logic [31:0] rs2;
      logic [31:0] rdata;
      int          stall_n;  // cycles the slave stalls stb
      int          ack_dly;  // WAIT cycles until ack (0 = ack with acceptance)
      bit          no_ack;
   } stim_t;

   typedef struct {
      int          stall;
      int          stb;
      int          waits;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] load;
      bit          mis;
      bit          err;
      bit          wr_rd;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   // Reference: access of `size` bytes at byte offset `off` within the word.
   function automatic exp_t model(input stim_t s);
      exp_t        e;
      int          size, off;
      bit          mem, go;
      logic [31:0] mask, v;
      size = size_of(s.f3);
      off  = int'(s.y % 4);
      mem  = (s.kind < 2);
      e.mis = mem && ((off % size) != 0);
      go    = mem && !e.mis;
      e.stb   = go ? s.stall_n + 1 : 0;
      e.waits = go ? (s.no_ack ? TMO : s.ack_dly) : 0;
      e.stall = go ? 2 + s.stall_n + e.waits : 0;
      e.err   = go && s.no_ack;
      e.sel   = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = s.rs2[8*(i % size) +: 8];
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (s.rdata >> (8 * off)) & mask;
      if (s.f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
      e.load  = v;
      e.wr_rd = (s.kind == 2) || (s.kind == 0 && go && !s.no_ack);
      return e;
   endfunction

   task automatic run(input stim_t s, input exp_t e, input int flush_c, input string tag);
      logic [31:0] pc, rd;
      logic [4:0]  rda;
      int          stall_cnt, stb_cnt, wait_cnt, stall_left;
      bit          accepted, done;
      pc = $urandom; rd = $urandom; rda = 5'($urandom);
      i_y = s.y; i_rs2 = s.rs2; i_funct3 = s.f3;
      i_opcode = (s.kind == 0) ? OPW'(1) << LDB : (s.kind == 1) ? OPW'(1) << STB : OPW'(1) << 5;
      i_pc = pc; i_rd_addr = rda; i_rd = rd; i_rd_valid = 1'b1; i_wr_rd = 1'b1;
      i_ce = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
      stall_cnt = 0; stb_cnt = 0; wait_cnt = 0; stall_left = s.stall_n;
      accepted = 1'b0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         i_flush = (c == flush_c);
         bus.wb_ack = 1'b0; bus.wb_stall = 1'b0; bus.wb_rdata = $urandom;
         if (bus.wb_stb) begin
            stb_cnt++;
            chk({tag, " cyc with stb"}, 32'(bus.wb_cyc), 32'd1);
            chk({tag, " addr"}, bus.wb_addr, s.y & ~32'd3);
            chk({tag, " sel"}, 32'(bus.wb_sel), 32'(e.sel));
            chk({tag, " we"}, 32'(bus.wb_we), 32'(s.kind == 1));
            if (s.kind == 1) chk({tag, " wdata"}, bus.wb_wdata, e.wdata);
            if (stall_left > 0) begin
               bus.wb_stall = 1'b1;
               stall_left--;
            end else begin
               accepted = 1'b1;
               if (!s.no_ack && s.ack_dly == 0) begin
                  bus.wb_ack = 1'b1; bus.wb_rdata = s.rdata;
               end
            end
         end else if (bus.wb_cyc && accepted) begin
            wait_cnt++;
            if (!s.no_ack && wait_cnt == s.ack_dly) begin
               bus.wb_ack = 1'b1; bus.wb_rdata = s.rdata;
            end
         end
         @(negedge clk);
         if (c == flush_c) chk({tag, " o_flush"}, 32'(o_flush), 32'd1);
         if (o_stall) stall_cnt++;
         else done = 1'b1;
         @(posedge clk); #1;
      end
      i_flush = 1'b0; bus.wb_ack = 1'b0; bus.wb_stall = 1'b0;
      chk({tag, " completes in budget"}, 32'(done), 32'd1);
      chk({tag, " stall cycles"}, 32'(stall_cnt), 32'(e.stall));
      chk({tag, " stb cycles"}, 32'(stb_cnt), 32'(e.stb));
      chk({tag, " wait cycles"}, 32'(wait_cnt), 32'(e.waits));
      chk({tag, " cyc idle"}, 32'(bus.wb_cyc), 32'd0);
      if (flush_c >= 0) begin
         chk({tag, " o_ce dropped"}, 32'(o_ce), 32'd0);
      end else begin
         chk({tag, " o_ce"}, 32'(o_ce), 32'd1);
         chk({tag, " misaligned"}, 32'(o_misaligned), 32'(e.mis));
         chk({tag, " bus_err"}, 32'(o_bus_err), 32'(e.err));
         chk({tag, " wr_rd"}, 32'(o_wr_rd), 32'(e.wr_rd));
         chk({tag, " pc"}, o_pc, pc);
         chk({tag, " rd_addr"}, 32'(o_rd_addr), 32'(rda));
         chk({tag, " rd"}, o_rd, rd);
         chk({tag, " funct3"}, 32'(o_funct3), 32'(s.f3));
         chk({tag, " opcode"}, 32'(o_opcode), 32'(i_opcode));
         if (s.kind == 0 && !e.mis && !e.err) chk({tag, " load"}, o_data_load, e.load);
      end
      i_ce = 1'b0; i_opcode = '0;
      @(posedge clk); #1;
      chk({tag, " o_ce idle"}, 32'(o_ce), 32'd0);
   endtask

   vec_t tbl [14];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      stim_t       s;
      exp_t        e;
      logic [2:0]  lf3 [5];
      lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      //            kind f3    y        rs2           rdata       stl ack noack    stall stb wt sel   wdata         load          mis err wr
      tbl[0]  = '{'{0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 1'b0}, '{3,  1, 1, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1}};
      tbl[1]  = '{'{0, 3'd0, 32'h103, 32'h0,        32'h80123456, 0, 1, 1'b0}, '{3,  1, 1, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 1'b1}};
      tbl[2]  = '{'{0, 3'd4, 32'h103, 32'h0,        32'h80123456, 0, 1, 1'b0}, '{3,  1, 1, 4'h8, 32'h0,        32'h00000080, 1'b0, 1'b0, 1'b1}};
      tbl[3]  = '{'{1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0,        0, 1, 1'b0}, '{3,  1, 1, 4'hC, 32'hABCDABCD, 32'h0,        1'b0, 1'b0, 1'b0}};
      tbl[4]  = '{'{0, 3'd2, 32'h200, 32'h0,        32'h0BADF00D, 4, 1, 1'b0}, '{7,  5, 1, 4'hF, 32'h0,        32'h0BADF00D, 1'b0, 1'b0, 1'b1}};
      tbl[5]  = '{'{0, 3'd2, 32'h101, 32'h0,        32'h0,        0, 1, 1'b0}, '{0,  0, 0, 4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0}};
      tbl[6]  = '{'{0, 3'd2, 32'h104, 32'h0,        32'h0,        0, 0, 1'b1}, '{10, 1, 8, 4'hF, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0}};
      tbl[7]  = '{'{0, 3'd1, 32'h102, 32'h0,        32'h80017777, 0, 0, 1'b0}, '{2,  1, 0, 4'hC, 32'h0,        32'hFFFF8001, 1'b0, 1'b0, 1'b1}};
      tbl[8]  = '{'{0, 3'd5, 32'h102, 32'h0,        32'h80017777, 0, 0, 1'b0}, '{2,  1, 0, 4'hC, 32'h0,        32'h00008001, 1'b0, 1'b0, 1'b1}};
      tbl[9]  = '{'{1, 3'd0, 32'h001, 32'h000000A5, 32'h0,        2, 2, 1'b0}, '{6,  3, 2, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b0}};
      tbl[10] = '{'{1, 3'd2, 32'h010, 32'hCAFEF00D, 32'h0,        0, 3, 1'b0}, '{5,  1, 3, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1'b0}};
      tbl[11] = '{'{2, 3'd2, 32'h103, 32'h0,        32'h0,        0, 0, 1'b0}, '{0,  0, 0, 4'hF, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1}};
      tbl[12] = '{'{0, 3'd1, 32'h101, 32'h0,        32'h0,        0, 1, 1'b0}, '{0,  0, 0, 4'h3, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0}};
      tbl[13] = '{'{0, 3'd0, 32'h201, 32'h0,        32'h12347F56, 1, 1, 1'b0}, '{4,  2, 1, 4'h2, 32'h0,        32'h0000007F, 1'b0, 1'b0, 1'b1}};

      rst_n = 1'b0;
      i_y = '0; i_rs2 = '0; i_funct3 = '0; i_opcode = '0; i_pc = '0; i_rd_addr = '0; i_rd = '0;
      i_rd_valid = 1'b0; i_wr_rd = 1'b0; i_ce = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
      bus.wb_ack = 1'b0; bus.wb_stall = 1'b0; bus.wb_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset cyc", 32'(bus.wb_cyc), 32'd0);
      chk("reset stb", 32'(bus.wb_stb), 32'd0);
      chk("reset o_ce", 32'(o_ce), 32'd0);
      chk("reset o_stall", 32'(o_stall), 32'd0);
      chk("reset data_load", o_data_load, 32'd0);
      chk("reset pc", o_pc, 32'd0);
      chk("reset bus_err", 32'(o_bus_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) run(tbl[i].s, tbl[i].e, -1, $sformatf("vec%0d", i));

      // Flush pulse in the first WAIT cycle: bus finishes, result dropped.
      s = '{0, 3'd2, 32'h40, 32'h0, 32'h11223344, 0, 3, 1'b0};
      run(s, model(s), 2, "flush");

      // Asynchronous reset in the middle of WAIT.
      i_y = 32'h300; i_funct3 = 3'd2; i_opcode = OPW'(1) << LDB; i_ce = 1'b1;
      i_flush = 1'b0; i_stall = 1'b0; bus.wb_stall = 1'b0; bus.wb_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rstwait in WAIT", 32'({bus.wb_cyc, bus.wb_stb}), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("rstwait cyc", 32'(bus.wb_cyc), 32'd0);
      chk("rstwait stb", 32'(bus.wb_stb), 32'd0);
      chk("rstwait o_stall", 32'(o_stall), 32'd0);
      chk("rstwait o_ce", 32'(o_ce), 32'd0);
      i_ce = 1'b0; i_opcode = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("rstwait idle cyc", 32'(bus.wb_cyc), 32'd0);
         chk("rstwait idle o_stall", 32'(o_stall), 32'd0);
      end

      // Random traffic against the model.
      for (int n = 0; n < 40; n++) begin
         s.kind = int'($urandom_range(0, 2));
         if (s.kind == 0) s.f3 = lf3[$urandom_range(0, 4)];
         else if (s.kind == 1) s.f3 = 3'($urandom_range(0, 2));
         else s.f3 = 3'($urandom_range(0, 7));
         s.y = $urandom;
         if ($urandom_range(0, 1) == 1) s.y = s.y & ~32'(size_of(s.f3) - 1);
         s.rs2 = $urandom; s.rdata = $urandom;
         s.stall_n = int'($urandom_range(0, 3));
         s.ack_dly = int'($urandom_range(0, 4));
         s.no_ack = ($urandom_range(0, 7) == 0);
         e = model(s);
         run(s, e, -1, $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
